alu_issue_stage: RTL and testbench

Sequential front-end for the 4-bit ALU. It accepts register-addressed operations over a valid/ready handshake and holds a small register file. Each operation drives registered operands and an opcode into the combinational ALU, captures the result and flags, writes the result back to the register file, and presents it downstream under valid/ready backpressure. The block sits directly upstream of the ALU and also consumes the ALU's outputs.

---
 rtl/alu_issue_stage.sv | 119 +++++++++++
 tb/tb_alu_issue_stage.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// Issue stage in front of the 4-bit combinational ALU: a small register file, registered ALU operands,
// and a one-entry response buffer with valid/ready handshakes on both sides.
module alu_issue_stage #(
    parameter int WIDTH = 4,
    parameter int NREGS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_load,
    input  logic [2:0]               in_opcode,
    input  logic [$clog2(NREGS)-1:0] in_rd,
    input  logic [$clog2(NREGS)-1:0] in_rs1,
    input  logic [$clog2(NREGS)-1:0] in_rs2,
    input  logic [WIDTH-1:0]         in_imm,
    output logic [WIDTH-1:0]         alu_a,
    output logic [WIDTH-1:0]         alu_b,
    output logic [2:0]               alu_opcode,
    input  logic [WIDTH-1:0]         alu_result,
    input  logic                     alu_zero,
    input  logic                     alu_carry,
    input  logic                     alu_overflow,
    input  logic                     alu_negative,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_result,
    output logic [$clog2(NREGS)-1:0] out_rd,
    output logic [3:0]               out_flags,
    input  logic [$clog2(NREGS)-1:0] dbg_addr,
    output logic [WIDTH-1:0]         dbg_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] regfile [NREGS];
    logic             accept;

    // Gating with rst_n keeps ready low for the whole time reset is held.
    assign in_ready = (state == IDLE) & rst_n;
    assign accept   = in_valid & in_ready;
    assign dbg_data = regfile[dbg_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept && !in_load) begin
                    next_state = EXEC;
                end
            end
            EXEC: next_state = RESP;
            RESP: begin
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Register file writes happen only in IDLE (loads) or at EXEC exit, so they never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regfile[i] <= '0;
            end
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_rd     <= '0;
            out_flags  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (in_load) begin
                            regfile[in_rd] <= in_imm;
                        end else begin
                            alu_a      <= regfile[in_rs1];
                            alu_b      <= regfile[in_rs2];
                            alu_opcode <= in_opcode;
                            out_rd     <= in_rd;
                        end
                    end
                end
                EXEC: begin
                    out_result      <= alu_result;
                    regfile[out_rd] <= alu_result;
                    out_flags       <= {alu_zero, alu_carry, alu_overflow, alu_negative};
                    out_valid       <= 1'b1;
                end
                RESP: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Testbench for alu_issue_stage: stands in for the ALU, runs a vector table, hand-written corner
// sequences and a randomized run against a register-file reference model.
module tb_alu_issue_stage;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic       in_load;
    logic [2:0] in_opcode;
    logic [1:0] in_rd;
    logic [1:0] in_rs1;
    logic [1:0] in_rs2;
    logic [3:0] in_imm;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_opcode;
    logic [3:0] alu_result;
    logic       alu_zero;
    logic       alu_carry;
    logic       alu_overflow;
    logic       alu_negative;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_result;
    logic [1:0] out_rd;
    logic [3:0] out_flags;
    logic [1:0] dbg_addr;
    logic [3:0] dbg_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] ref_rf [4];

    typedef struct packed {
        logic [3:0] res;
        logic [3:0] flags;
    } alu_out_t;

    typedef struct {
        logic       ld;
        logic [2:0] op;
        logic [1:0] rd;
        logic [1:0] rs1;
        logic [1:0] rs2;
        logic [3:0] imm;
        logic [3:0] exp_res;
        logic [3:0] exp_flags;
    } vec_t;

    vec_t     vecs [13];
    alu_out_t alu_now;

    alu_issue_stage #(.WIDTH(4), .NREGS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_load(in_load), .in_opcode(in_opcode),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
        .alu_overflow(alu_overflow), .alu_negative(alu_negative),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_rd(out_rd), .out_flags(out_flags),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU behaviour from plain integer arithmetic: unsigned carry/borrow, signed range overflow.
    // Opcodes: 0 ADD, 1 SUB, 2 INC, 3 DEC, 4 AND, 5 OR, 6 XOR, 7 NOT.
    function automatic alu_out_t alu_ref(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        int ua, ub, sa, sb, r, sr;
        logic c, v;
        alu_out_t o;
        ua = int'(a);
        ub = int'(b);
        sa = a[3] ? ua - 16 : ua;
        sb = b[3] ? ub - 16 : ub;
        r  = 0;
        sr = 0;
        c  = 1'b0;
        case (op)
            3'd0: begin r = ua + ub; c = (r > 15); sr = sa + sb; end
            3'd1: begin r = ua - ub; c = (ua < ub); sr = sa - sb; end
            3'd2: begin r = ua + 1;  c = (r > 15); sr = sa + 1; end
            3'd3: begin r = ua - 1;  c = (ua < 1); sr = sa - 1; end
            3'd4: r = ua & ub;
            3'd5: r = ua | ub;
            3'd6: r = ua ^ ub;
            default: r = 15 - ua;
        endcase
        v = (op <= 3'd3) && (sr > 7 || sr < -8);
        o.res   = 4'(r & 15);
        o.flags = {o.res == 4'd0, c, v, o.res[3]};
        return o;
    endfunction

    always_comb begin
        alu_now = alu_ref(alu_opcode, alu_a, alu_b);
        alu_result = alu_now.res;
        {alu_zero, alu_carry, alu_overflow, alu_negative} = alu_now.flags;
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        int cnt = 0;
        while (!in_ready && cnt < 20) begin
            step();
            cnt++;
        end
        check_output({name, "_ready_timeout"}, 32'(in_ready), 32'd1);
    endtask

    task automatic apply_stimulus_load(input logic [1:0] rd, input logic [3:0] imm);
        in_valid = 1'b1;
        in_load  = 1'b1;
        in_rd    = rd;
        in_imm   = imm;
        wait_ready("load");
        step();
        in_valid = 1'b0;
        in_load  = 1'b0;
        ref_rf[rd] = imm;
        dbg_addr = rd;
        #1;
        check_output("load_dbg", 32'(dbg_data), 32'(imm));
        check_output("load_ready_b2b", 32'(in_ready), 32'd1);
    endtask

    task automatic apply_stimulus_op(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                                     input logic [1:0] rs2, input logic [3:0] exp_res,
                                     input logic [3:0] exp_flags, input int stall);
        in_valid  = 1'b1;
        in_load   = 1'b0;
        in_opcode = op;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        wait_ready("op");
        step();
        in_valid = 1'b0;
        check_output("exec_valid_low", 32'(out_valid), 32'd0);
        check_output("exec_ready_low", 32'(in_ready), 32'd0);
        step();
        check_output("resp_valid", 32'(out_valid), 32'd1);
        check_output("resp_result", 32'(out_result), 32'(exp_res));
        check_output("resp_flags", 32'(out_flags), 32'(exp_flags));
        check_output("resp_rd", 32'(out_rd), 32'(rd));
        for (int k = 0; k < stall; k++) begin
            step();
            check_output("stall_valid", 32'(out_valid), 32'd1);
            check_output("stall_result", 32'(out_result), 32'(exp_res));
            check_output("stall_flags", 32'(out_flags), 32'(exp_flags));
            check_output("stall_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_output("drain_valid", 32'(out_valid), 32'd0);
        check_output("drain_ready", 32'(in_ready), 32'd1);
        ref_rf[rd] = exp_res;
        dbg_addr = rd;
        #1;
        check_output("wb_dbg", 32'(dbg_data), 32'(exp_res));
    endtask

    initial begin
        alu_out_t e;
        rst_n = 1'b0; in_valid = 1'b0; in_load = 1'b0; in_opcode = '0;
        in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
        out_ready = 1'b0; dbg_addr = '0;
        for (int i = 0; i < 4; i++) ref_rf[i] = '0;

        // ld, op, rd, rs1, rs2, imm, exp_res, exp_flags {Z,C,V,N}
        vecs[0]  = '{1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 4'd5,  4'd5,  4'b0000};
        vecs[1]  = '{1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 4'd3,  4'd3,  4'b0000};
        vecs[2]  = '{1'b0, 3'd0, 2'd2, 2'd0, 2'd1, 4'd0,  4'd8,  4'b0011};
        vecs[3]  = '{1'b1, 3'd0, 2'd3, 2'd0, 2'd0, 4'd15, 4'd15, 4'b0000};
        vecs[4]  = '{1'b0, 3'd2, 2'd3, 2'd3, 2'd3, 4'd0,  4'd0,  4'b1100};
        vecs[5]  = '{1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 4'd9,  4'd9,  4'b0000};
        vecs[6]  = '{1'b0, 3'd6, 2'd1, 2'd0, 2'd0, 4'd0,  4'd0,  4'b1000};
        vecs[7]  = '{1'b0, 3'd1, 2'd2, 2'd0, 2'd2, 4'd0,  4'd1,  4'b0000};
        vecs[8]  = '{1'b0, 3'd7, 2'd0, 2'd1, 2'd1, 4'd0,  4'd15, 4'b0001};
        vecs[9]  = '{1'b0, 3'd4, 2'd3, 2'd0, 2'd2, 4'd0,  4'd1,  4'b0000};
        vecs[10] = '{1'b0, 3'd3, 2'd1, 2'd1, 2'd1, 4'd0,  4'd15, 4'b0101};
        vecs[11] = '{1'b0, 3'd5, 2'd2, 2'd3, 2'd1, 4'd0,  4'd15, 4'b0001};
        vecs[12] = '{1'b0, 3'd0, 2'd0, 2'd0, 2'd0, 4'd0,  4'd14, 4'b0101};

        #12;
        $display("[TB] reset state");
        check_output("rst_in_ready", 32'(in_ready), 32'd0);
        check_output("rst_alu_a", 32'(alu_a), 32'd0);
        check_output("rst_alu_b", 32'(alu_b), 32'd0);
        check_output("rst_alu_opcode", 32'(alu_opcode), 32'd0);
        check_output("rst_out_valid", 32'(out_valid), 32'd0);
        check_output("rst_out_result", 32'(out_result), 32'd0);
        check_output("rst_out_rd", 32'(out_rd), 32'd0);
        check_output("rst_out_flags", 32'(out_flags), 32'd0);
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i);
            #1;
            check_output("rst_regfile", 32'(dbg_data), 32'd0);
        end
        step();
        rst_n = 1'b1;
        #1;
        check_output("ready_after_reset", 32'(in_ready), 32'd1);

        $display("[TB] vector table");
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].ld) begin
                apply_stimulus_load(vecs[i].rd, vecs[i].imm);
            end else begin
                apply_stimulus_op(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
                                  vecs[i].exp_res, vecs[i].exp_flags, 0);
            end
        end

        $display("[TB] backpressure");
        apply_stimulus_load(2'd0, 4'd5);
        apply_stimulus_load(2'd1, 4'd3);
        apply_stimulus_op(3'd0, 2'd2, 2'd0, 2'd1, 4'd8, 4'b0011, 5);

        $display("[TB] blocked input");
        apply_stimulus_load(2'd0, 4'd2);
        e = alu_ref(3'd0, ref_rf[0], ref_rf[1]);
        in_valid = 1'b1; in_load = 1'b0; in_opcode = 3'd0;
        in_rd = 2'd2; in_rs1 = 2'd0; in_rs2 = 2'd1;
        wait_ready("blk");
        step();
        in_load = 1'b1; in_rd = 2'd0; in_imm = 4'd7;
        dbg_addr = 2'd0;
        #1;
        check_output("blk_exec_ready", 32'(in_ready), 32'd0);
        step();
        check_output("blk_resp_valid", 32'(out_valid), 32'd1);
        check_output("blk_resp_result", 32'(out_result), 32'(e.res));
        check_output("blk_r0_exec", 32'(dbg_data), 32'd2);
        step();
        check_output("blk_r0_resp", 32'(dbg_data), 32'd2);
        check_output("blk_resp_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_output("blk_idle_ready", 32'(in_ready), 32'd1);
        check_output("blk_r0_idle", 32'(dbg_data), 32'd2);
        step();
        in_valid = 1'b0; in_load = 1'b0;
        check_output("blk_r0_loaded", 32'(dbg_data), 32'd7);
        ref_rf[2] = e.res;
        ref_rf[0] = 4'd7;

        $display("[TB] reset mid-operation");
        apply_stimulus_load(2'd2, 4'd6);
        in_valid = 1'b1; in_load = 1'b0; in_opcode = 3'd0;
        in_rd = 2'd2; in_rs1 = 2'd0; in_rs2 = 2'd1;
        wait_ready("rst_mid");
        step();
        in_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        dbg_addr = 2'd2;
        #1;
        check_output("mid_rst_valid", 32'(out_valid), 32'd0);
        check_output("mid_rst_ready", 32'(in_ready), 32'd0);
        check_output("mid_rst_r2", 32'(dbg_data), 32'd0);
        step();
        check_output("mid_rst_valid_hold", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) ref_rf[i] = '0;
        #1;
        check_output("mid_rst_ready_release", 32'(in_ready), 32'd1);
        step();
        check_output("mid_rst_no_resp", 32'(out_valid), 32'd0);
        check_output("mid_rst_r2_after", 32'(dbg_data), 32'd0);

        $display("[TB] randomized run");
        for (int i = 0; i < 60; i++) begin
            logic [1:0] rd, rs1, rs2;
            logic [2:0] op;
            rd  = 2'($urandom_range(0, 3));
            rs1 = 2'($urandom_range(0, 3));
            rs2 = 2'($urandom_range(0, 3));
            op  = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) begin
                apply_stimulus_load(rd, 4'($urandom_range(0, 15)));
            end else begin
                e = alu_ref(op, ref_rf[rs1], ref_rf[rs2]);
                apply_stimulus_op(op, rd, rs1, rs2, e.res, e.flags, int'($urandom_range(0, 2)));
            end
        end
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i);
            #1;
            check_output("final_regfile", 32'(dbg_data), 32'(ref_rf[i]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
